// File: rtl/ternary_stim_gen_pkg.sv
// Shared types and constants for the ternary stimulus generator: stream modes, FSM states,
// LFSR taps, per-lane seed stride and the seed/step helpers a software replay model mirrors.
package ternary_stim_gen_pkg;

   localparam int D               = 8;
   localparam int FixedPointWidth = 16;

   localparam logic [31:0] StimLfsrTaps   = 32'h8020_0003;
   localparam logic [31:0] StimSeedStride = 32'h9E37_79B9;

   typedef enum logic {
      StimVector  = 1'b0,
      StimTernary = 1'b1
   } stim_mode_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } stim_state_e;

   // An all-zero Galois LFSR is stuck, so a zero lane seed is replaced by 1.
   function automatic logic [31:0] lane_seed(input logic [31:0] seed, input int unsigned lane);
      logic [31:0] s;
      s = seed ^ (32'(lane) * StimSeedStride);
      return (s == 32'h0) ? 32'h1 : s;
   endfunction

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? StimLfsrTaps : 32'h0);
   endfunction

endpackage

// File: rtl/stim_lfsr_lane.sv
// One output lane: 32-bit Galois LFSR, hold register with full flag, and rejection of the -2 code.
// Draws when empty or on a non-final handshake; a full lane never advances while stalled.
module stim_lfsr_lane
   import ternary_stim_gen_pkg::*;
#(
   parameter int          W         = 16,
   parameter logic [31:0] ResetSeed = 32'h1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [31:0]      seed_i,
   input  logic             run_i,
   input  stim_mode_e       mode_i,
   input  logic             hs_i,
   input  logic             clear_i,
   output logic             full_o,
   output logic [W-1:0]     data_o
);

   logic [31:0]  lfsr_q, lfsr_d;
   logic         full_q, full_d;
   logic [W-1:0] dat_q, dat_d;

   logic         draw;
   logic         rejected;
   logic [W-1:0] draw_val;

   always_comb begin
      draw     = run_i && !clear_i && (!full_q || hs_i);
      rejected = (mode_i == StimTernary) && (lfsr_q[1:0] == 2'b10);
      draw_val = (mode_i == StimTernary) ? {{(W-2){lfsr_q[1]}}, lfsr_q[1:0]} : lfsr_q[W-1:0];

      lfsr_d = lfsr_q;
      full_d = full_q;
      dat_d  = dat_q;
      if (load_i) begin
         lfsr_d = seed_i;
      end else if (clear_i) begin
         full_d = 1'b0;
         dat_d  = '0;
      end else if (draw) begin
         lfsr_d = lfsr_step(lfsr_q);
         if (rejected) begin
            full_d = 1'b0;
         end else begin
            full_d = 1'b1;
            dat_d  = draw_val;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lfsr_q <= ResetSeed;
         full_q <= 1'b0;
         dat_q  <= '0;
      end else begin
         lfsr_q <= lfsr_d;
         full_q <= full_d;
         dat_q  <= dat_d;
      end
   end

   assign full_o = full_q;
   assign data_o = dat_q;

endmodule

// File: rtl/ternary_stim_gen.sv
// Seedable random vector/ternary-matrix beat source; first beat one cycle after start (vector mode).
// Beats stall cleanly under !ready_i. TERNARY_STIM_GEN_SIGNATURE_EN builds the stream signature.
module ternary_stim_gen #(
   parameter int          Lanes = 4,
   parameter int          D     = ternary_stim_gen_pkg::D,
   parameter logic [31:0] Seed  = 32'hACE1_2024
) (
   input  logic                                                clk_i,
   input  logic                                                rst_i,
   input  logic                                                start_i,
   input  logic                                                mode_i,
   input  logic                                                load_seed_i,
   input  logic [31:0]                                         seed_i,
   output logic                                                valid_o,
   input  logic                                                ready_i,
   output logic [Lanes*ternary_stim_gen_pkg::FixedPointWidth-1:0] data_o,
   output logic                                                last_o,
   output logic                                                busy_o,
   output logic                                                done_o,
   output logic [31:0]                                         signature_o
);
   import ternary_stim_gen_pkg::*;

   localparam int W    = FixedPointWidth;
   localparam int CntW = $clog2(D*D/Lanes + 1);
   localparam logic [CntW-1:0] VecLast = CntW'(D/Lanes - 1);
   localparam logic [CntW-1:0] MatLast = CntW'(D*D/Lanes - 1);

   stim_state_e     state_q, state_d;
   stim_mode_e      mode_q, mode_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic [Lanes-1:0]        full;
   logic [Lanes-1:0][W-1:0] lane_dat;
   logic [CntW-1:0]         last_idx;
   logic                    run, hs, final_hs, seed_load, start_acc;

   always_comb begin
      last_idx  = (mode_q == StimTernary) ? MatLast : VecLast;
      run       = (state_q == StRun);
      valid_o   = run && (&full);
      hs        = valid_o && ready_i;
      final_hs  = hs && (cnt_q == last_idx);
      seed_load = (state_q == StIdle) && load_seed_i;
      start_acc = (state_q == StIdle) && start_i && !load_seed_i;
      last_o    = valid_o && (cnt_q == last_idx);
      busy_o    = (state_q != StIdle);
      done_o    = (state_q == StDone);
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (start_acc) begin
               mode_d  = stim_mode_e'(mode_i);
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            if (final_hs) begin
               state_d = StDone;
            end else if (hs) begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         mode_q  <= StimVector;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
      end
   end

   for (genvar k = 0; k < Lanes; k++) begin : g_lane
      stim_lfsr_lane #(
         .W         (W),
         .ResetSeed (lane_seed(Seed, k))
      ) u_lane (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .load_i  (seed_load),
         .seed_i  (lane_seed(seed_i, k)),
         .run_i   (run),
         .mode_i  (mode_q),
         .hs_i    (hs),
         .clear_i (final_hs),
         .full_o  (full[k]),
         .data_o  (lane_dat[k])
      );
   end

   assign data_o = lane_dat;

`ifdef TERNARY_STIM_GEN_SIGNATURE_EN
   localparam int NChunk = (Lanes*W + 31) / 32;

   logic [31:0]          sig_q, sig_d;
   logic [31:0]          fold;
   logic [NChunk*32-1:0] dat_pad;

   always_comb begin
      dat_pad = '0;
      dat_pad[Lanes*W-1:0] = data_o;
      fold = '0;
      for (int c = 0; c < NChunk; c++) begin
         fold = fold ^ dat_pad[c*32 +: 32];
      end
      sig_d = sig_q;
      if (start_acc) begin
         sig_d = '0;
      end else if (hs) begin
         sig_d = {sig_q[30:0], sig_q[31]} ^ fold;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign signature_o = sig_q;
`else
   assign signature_o = '0;
`endif

endmodule

// File: tb/tb_ternary_stim_gen.sv
// Randomised bench for ternary_stim_gen: per-lane LFSR stream model with a per-cycle compare process.
module tb_ternary_stim_gen;
   import ternary_stim_gen_pkg::*;

   localparam int L  = 4;
   localparam int W  = FixedPointWidth;
   localparam int DW = L*W;
   localparam logic [31:0] DefSeed = 32'hACE1_2024;

   logic          clk, rst, start_i, mode_i, load_seed_i, ready_i;
   logic [31:0]   seed_i;
   logic          valid_o, last_o, busy_o, done_o;
   logic [DW-1:0] data_o;
   logic [31:0]   signature_o;

   ternary_stim_gen #(.Lanes(L), .D(D), .Seed(DefSeed)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start_i), .mode_i(mode_i),
      .load_seed_i(load_seed_i), .seed_i(seed_i), .valid_o(valid_o), .ready_i(ready_i),
      .data_o(data_o), .last_o(last_o), .busy_o(busy_o), .done_o(done_o),
      .signature_o(signature_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0]   m_lfsr [L];
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] got_q [$];
   int            m_idx, m_n;
   bit            m_busy, m_done_exp, m_mode, stall_prev;
   logic [31:0]   m_sig;
   logic [DW-1:0] prev_dat;
   logic          prev_last;
   int            cnt_m1 = 0, cnt_z = 0, cnt_p1 = 0, cnt_bad = 0;

   function automatic logic [31:0] seed_for(input logic [31:0] s, input int k);
      logic [31:0] t;
      t = s ^ (32'(k) * 32'h9E37_79B9);
      if (t == 32'h0) t = 32'h1;
      return t;
   endfunction

   function automatic logic [31:0] m_step(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   function automatic logic [31:0] fold32(input logic [DW-1:0] b);
      logic [31:0] f;
      f = '0;
      for (int c = 0; c < DW/32; c++) f = f ^ b[c*32 +: 32];
      return f;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < L; k++) m_lfsr[k] = seed_for(DefSeed, k);
      exp_q.delete();
      m_busy = 0; m_done_exp = 0; m_sig = '0; stall_prev = 0; m_idx = 0; m_n = 0;
   endtask

   // Each lane's stream is just its LFSR sequence with -2 codes dropped in matrix mode.
   task automatic gen_burst(input bit mode);
      logic [DW-1:0] beat;
      logic [31:0]   v;
      bit            got;
      m_n = mode ? D*D/L : D/L;
      for (int b = 0; b < m_n; b++) begin
         beat = '0;
         for (int k = 0; k < L; k++) begin
            got = 0;
            while (!got) begin
               v = m_lfsr[k];
               m_lfsr[k] = m_step(v);
               if (!mode) begin
                  beat[k*W +: W] = v[W-1:0];
                  got = 1;
               end else if (v[1:0] != 2'b10) begin
                  case (v[1:0])
                     2'b00:   beat[k*W +: W] = '0;
                     2'b01:   beat[k*W +: W] = W'(1);
                     default: beat[k*W +: W] = '1;
                  endcase
                  got = 1;
               end
            end
         end
         exp_q.push_back(beat);
      end
   endtask

   always @(negedge clk) begin : cmp
      logic [DW-1:0] e;
      logic [W-1:0]  lv;
      bit            hs, fin;
      if (rst) begin
         model_reset();
      end else begin
         hs  = valid_o && ready_i;
         fin = 0;
         chk("done", done_o, m_done_exp);
         chk("busy", busy_o, m_busy);
`ifdef TERNARY_STIM_GEN_SIGNATURE_EN
         chk("signature", signature_o, m_sig);
`else
         chk("signature_tied", signature_o, 0);
`endif
         if (!m_busy) chk("idle_valid_last", {valid_o, last_o}, 0);
         if (stall_prev) begin
            chk("stall_valid", valid_o, 1);
            chk("stall_data", data_o, prev_dat);
            chk("stall_last", last_o, prev_last);
         end
         if (hs) begin
            if (exp_q.size() == 0) begin
               chk("extra_beat", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", data_o, e);
               chk("beat_last", last_o, (m_idx == m_n-1));
               got_q.push_back(data_o);
               m_sig = {m_sig[30:0], m_sig[31]} ^ fold32(e);
               if (m_mode) begin
                  for (int k = 0; k < L; k++) begin
                     lv = data_o[k*W +: W];
                     if (lv == '1) cnt_m1++;
                     else if (lv == '0) cnt_z++;
                     else if (lv == W'(1)) cnt_p1++;
                     else cnt_bad++;
                  end
               end
               fin = (m_idx == m_n-1);
               m_idx++;
            end
         end
         stall_prev = valid_o && !ready_i;
         prev_dat   = data_o;
         prev_last  = last_o;
         if (!m_busy) begin
            if (load_seed_i) begin
               for (int k = 0; k < L; k++) m_lfsr[k] = seed_for(seed_i, k);
            end else if (start_i) begin
               m_busy = 1; m_mode = mode_i; m_sig = '0; m_idx = 0;
               gen_burst(mode_i);
            end
         end
         if (m_done_exp) begin
            m_busy = 0;
            m_done_exp = 0;
         end
         if (fin) m_done_exp = 1;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [31:0] s);
      load_seed_i = 1; seed_i = s;
      tick();
      load_seed_i = 0;
   endtask

   // rmode: 0 ready high, 1 random ready, 2 one 5-cycle stall on the first valid beat
   task automatic run_burst(input bit mode, input int rmode);
      bit seen, stalled;
      got_q.delete();
      mode_i = mode; start_i = 1; ready_i = 1;
      tick();
      start_i = 0;
      seen = 0; stalled = 0;
      for (int cyc = 0; cyc < 4000 && !seen; cyc++) begin
         if (done_o) begin
            seen = 1;
         end else begin
            if (rmode == 1) ready_i = ($urandom_range(0, 3) != 0);
            else if (rmode == 2 && valid_o && !stalled) begin
               ready_i = 0;
               repeat (5) tick();
               ready_i = 1;
               stalled = 1;
            end
            tick();
         end
      end
      if (!seen) chk("done_timeout", 0, 1);
      ready_i = 1;
      tick();
   endtask

   logic [DW-1:0] run_a [$];
   logic [31:0]   sig_a;
   int            diffs, tot;

   initial begin
      rst = 1; start_i = 0; mode_i = 0; load_seed_i = 0; seed_i = '0; ready_i = 1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", valid_o, 0);
      chk("rst_last", last_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_data", data_o, 0);
      chk("rst_sig", signature_o, 0);
      rst = 0;
      tick();

      // vector burst, ready high: exact cycle timing and literal first beats
      got_q.delete();
      start_i = 1; mode_i = 0;
      tick();
      start_i = 0;
      chk("lat_after_start", {busy_o, valid_o}, 2'b10);
      tick();
      chk("lat_vec_beat1", {valid_o, last_o}, 2'b10);
      tick();
      chk("lat_vec_beat2", {valid_o, last_o}, 2'b11);
      tick();
      chk("lat_done", {done_o, valid_o}, 2'b10);
      tick();
      chk("lat_idle", {busy_o, done_o}, 2'b00);
      chk("vec_beats", got_q.size(), 2);
      if (got_q.size() == 2) begin
         chk("vec_beat0_lit", got_q[0], 64'h4D0F_D356_599D_2024);
         chk("vec_beat1_lit", got_q[1], 64'hA684_E9AB_2CCD_9012);
      end

      // stalled stream must equal the unstalled one from the same seed
      do_load(DefSeed);
      run_burst(0, 2);
      run_a = got_q;
      do_load(DefSeed);
      run_burst(0, 0);
      chk("stall_len", got_q.size(), run_a.size());
      diffs = 0;
      for (int i = 0; i < got_q.size() && i < run_a.size(); i++)
         if (got_q[i] !== run_a[i]) diffs++;
      chk("stall_stream_eq", diffs, 0);
      if (run_a.size() > 0) chk("stall_beat0_lit", run_a[0], 64'h4D0F_D356_599D_2024);

      // reloaded seed replays stream and signature
      do_load(32'h1234_5678);
      run_burst(1, 1);
      run_a = got_q; sig_a = signature_o;
      do_load(32'h1234_5678);
      run_burst(1, 1);
      chk("reload_len", got_q.size(), 16);
      diffs = 0;
      for (int i = 0; i < got_q.size() && i < run_a.size(); i++)
         if (got_q[i] !== run_a[i]) diffs++;
      chk("reload_stream_eq", diffs, 0);
      chk("reload_sig_eq", signature_o, sig_a);

      do_load(32'h0);
      run_burst(0, 0);
      if (got_q.size() > 0) begin
         chk("seed0_lane0", got_q[0][15:0], 16'h0001);
         chk("seed0_lane1", got_q[0][31:16], 16'h79B9);
      end else chk("seed0_beats", 0, 1);

      // async reset on the 3rd matrix beat
      mode_i = 1; start_i = 1; ready_i = 1;
      tick();
      start_i = 0;
      for (int cyc = 0; cyc < 500; cyc++) begin
         if (m_idx == 2 && valid_o) break;
         tick();
      end
      rst = 1;
      #1;
      chk("arst_valid", valid_o, 0);
      chk("arst_last", last_o, 0);
      chk("arst_busy", busy_o, 0);
      chk("arst_data", data_o, 0);
      chk("arst_sig", signature_o, 0);
      tick();
      rst = 0;
      tick();
      run_burst(0, 0);
      if (got_q.size() > 0) chk("post_rst_lit", got_q[0], 64'h4D0F_D356_599D_2024);
      else chk("post_rst_beats", 0, 1);
      run_burst(1, 1);

      // start/load while busy are ignored
      mode_i = 0; start_i = 1; ready_i = 0;
      tick();
      start_i = 1; mode_i = 1; load_seed_i = 1; seed_i = 32'hDEAD_BEEF;
      repeat (3) tick();
      start_i = 0; load_seed_i = 0; ready_i = 1;
      for (int cyc = 0; cyc < 100 && !done_o; cyc++) tick();
      chk("busy_start_done", done_o, 1);
      tick();

      // load wins over start in the same idle cycle
      load_seed_i = 1; start_i = 1; mode_i = 0; seed_i = 32'h1234_5678;
      tick();
      load_seed_i = 0; start_i = 0;
      chk("ld_start_prio", busy_o, 0);
      run_burst(0, 0);
      if (got_q.size() > 0) chk("ld_start_seed", got_q[0][15:0], 16'h5678);
      else chk("ld_start_beats", 0, 1);

      // matrix bursts from random seeds with random backpressure
      cnt_m1 = 0; cnt_z = 0; cnt_p1 = 0; cnt_bad = 0;
      for (int b = 0; b < 500; b++) begin
         do_load($urandom);
         run_burst(1, 1);
      end
      tot = cnt_m1 + cnt_z + cnt_p1;
      chk("tern_samples", tot, 500*16*L);
      chk("tern_invalid", cnt_bad, 0);
      chk("freq_m1", (cnt_m1*1000 >= tot*300) && (cnt_m1*1000 <= tot*360), 1);
      chk("freq_z",  (cnt_z*1000  >= tot*300) && (cnt_z*1000  <= tot*360), 1);
      chk("freq_p1", (cnt_p1*1000 >= tot*300) && (cnt_p1*1000 <= tot*360), 1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
